// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared state, funct3 encodings and lane helpers for the MEM-stage access unit
package memory_access_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} size_t;

   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

   // Any encoding that is not a byte or halfword access behaves as a word access
   function automatic size_t size_of(input logic [2:0] f);
      return f[1:0] == 2'b00 ? SIZE_B : f[1:0] == 2'b01 ? SIZE_H : SIZE_W;
   endfunction

   function automatic logic [3:0] byte_enable(input size_t s, input logic [1:0] a);
      return s == SIZE_B ? 4'b0001 << a : s == SIZE_H ? 4'b0011 << a : 4'b1111;
   endfunction

   function automatic logic misaligned(input size_t s, input logic [1:0] a);
      return s == SIZE_H ? a[0] : s == SIZE_W ? |a : 1'b0;
   endfunction

endpackage

// File: rtl/memory_access_unit_load_extender.sv
// load_extender: picks the addressed byte/halfword lane of a bus word and sign- or zero-extends it
module load_extender
   import memory_access_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   size_t       size;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      size      = size_of(funct3);
      lane_byte = raw[{offset, 3'b000} +: 8];
      lane_half = offset[1] ? raw[31:16] : raw[15:0];
      result    = size == SIZE_B ? {{24{lane_byte[7] & ~funct3[2]}}, lane_byte} :
                  size == SIZE_H ? {{16{lane_half[15] & ~funct3[2]}}, lane_half} : raw;
   end

endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: MEM-stage load/store engine running a req/ready bus handshake and stalling the pipeline
module memory_access_unit
   import memory_access_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     memoryRead,
   input  logic                     memoryWrite,
   input  logic [2:0]               funct3,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [31:0]              writeData,
   output logic                     busRequest,
   output logic                     busWrite,
   output logic [ADDRESS_WIDTH-1:0] busAddress,
   output logic [31:0]              busWriteData,
   output logic [3:0]               busByteEnable,
   input  logic                     busReady,
   input  logic [31:0]              busReadData,
   output logic [31:0]              memoryReadData,
   output logic                     pipelineStall,
   output logic                     misalignedFault,
   output logic                     busError
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t                   state, next_state;
   logic [ADDRESS_WIDTH-1:0] address_q;
   logic [2:0]               funct3_q;
   logic [31:0]              write_data_q;
   logic                     write_q;
   logic [CW-1:0]            count;
   logic [31:0]              extended;
   logic                     request, timeout, in_misaligned;
   size_t                    size_q;

   assign request       = memoryRead | memoryWrite;
   assign in_misaligned = misaligned(size_of(funct3), address[1:0]);
   assign timeout       = count == LAST;
   assign size_q        = size_of(funct3_q);

   // Bus fields come only from latched values so they stay stable for the whole handshake
   assign busWrite      = write_q;
   assign busAddress    = {address_q[ADDRESS_WIDTH-1:2], 2'b00};
   assign busByteEnable = byte_enable(size_q, address_q[1:0]);
   assign busWriteData  = size_q == SIZE_B ? {4{write_data_q[7:0]}} :
                          size_q == SIZE_H ? {2{write_data_q[15:0]}} : write_data_q;

   load_extender u_load_extender (
      .raw    (busReadData),
      .offset (address_q[1:0]),
      .funct3 (funct3_q),
      .result (extended)
   );

   always_comb begin
      next_state    = state;
      busRequest    = 1'b0;
      pipelineStall = 1'b0;
      case (state)
         IDLE: begin
            pipelineStall = request;
            next_state    = !request ? IDLE : in_misaligned ? DONE : ACCESS;
         end
         ACCESS: begin
            busRequest    = 1'b1;
            pipelineStall = 1'b1;
            next_state    = (busReady || timeout) ? DONE : ACCESS;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         address_q       <= '0;
         funct3_q        <= '0;
         write_data_q    <= '0;
         write_q         <= 1'b0;
         count           <= '0;
         memoryReadData  <= '0;
         misalignedFault <= 1'b0;
         busError        <= 1'b0;
      end else begin
         state           <= next_state;
         misalignedFault <= 1'b0;
         busError        <= 1'b0;
         if (state == IDLE && request) begin
            address_q       <= address;
            funct3_q        <= funct3;
            write_data_q    <= writeData;
            write_q         <= memoryWrite;
            count           <= '0;
            misalignedFault <= in_misaligned;
         end
         if (state == ACCESS) begin
            count <= count + 1'b1;
            if (busReady) begin
               if (!write_q)
                  memoryReadData <= extended;
            end else if (timeout) begin
               busError       <= 1'b1;
               memoryReadData <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: table-driven and randomized checks of the MEM-stage access unit
module tb_memory_access_unit;

   typedef struct {
      logic        mr, mw;
      logic [2:0]  f3;
      logic [31:0] addr, wd, word;
      int          waitc;
      logic [3:0]  be;
      logic [31:0] bwd, rd;
      int          lat;
      logic        mis, err;
   } vec_t;

   logic        clock = 0, reset = 1;
   logic        memoryRead = 0, memoryWrite = 0, busReady = 0;
   logic [2:0]  funct3 = 0;
   logic [31:0] address = 0, writeData = 0, busReadData = 0;
   logic        busRequest, busWrite, pipelineStall, misalignedFault, busError;
   logic [31:0] busAddress, busWriteData, memoryReadData;
   logic [3:0]  busByteEnable;

   int total = 0, passed = 0;
   logic [31:0] model_rd = 0;

   memory_access_unit #(.ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset(reset), .memoryRead(memoryRead), .memoryWrite(memoryWrite),
      .funct3(funct3), .address(address), .writeData(writeData), .busRequest(busRequest),
      .busWrite(busWrite), .busAddress(busAddress), .busWriteData(busWriteData),
      .busByteEnable(busByteEnable), .busReady(busReady), .busReadData(busReadData),
      .memoryReadData(memoryReadData), .pipelineStall(pipelineStall),
      .misalignedFault(misalignedFault), .busError(busError)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else passed++;
   endtask

   // Reference model: expected lanes, data and timing from the access rules, in plain arithmetic
   function automatic vec_t model(input vec_t v, input logic [31:0] prev);
      vec_t r = v;
      int sz = v.f3[1:0] == 2'b00 ? 1 : v.f3[1:0] == 2'b01 ? 2 : 4;
      int off = int'(v.addr % 4);
      int lane = sz == 2 ? (off / 2) * 2 : off;
      logic [31:0] mask = sz == 4 ? 32'hFFFFFFFF : (32'h1 << (8 * sz)) - 1;
      logic [31:0] val = (v.word >> (8 * lane)) & mask;
      r.be = sz == 4 ? 4'hF : 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) r.bwd[8*i +: 8] = v.wd[8*(i % sz) +: 8];
      if (sz < 4 && !v.f3[2] && val[8*sz-1]) val = val | ~mask;
      r.mis = (off % sz) != 0;
      r.err = !r.mis && v.waitc >= 16;
      r.lat = r.mis ? 2 : r.err ? 18 : 3 + v.waitc;
      r.rd  = r.mis ? prev : r.err ? 32'h0 : v.mw ? prev : val;
      return r;
   endfunction

   // Drives one request from IDLE, acts as the bus slave, and checks the whole transaction
   task automatic run_op(input string name, input vec_t v);
      int cyc = 1, stalls = 0, accesses = 0;
      logic stable = 1, done = 0;
      memoryRead = v.mr; memoryWrite = v.mw; funct3 = v.f3; address = v.addr;
      writeData = v.wd; busReadData = v.word; busReady = 0;
      #1;
      check({name, "_idle_stall"}, 32'(pipelineStall), 32'h1);
      stalls += int'(pipelineStall);
      while (!done && cyc < 40) begin
         @(negedge clock);
         busReady = 0;
         #1;
         cyc++;
         stalls += int'(pipelineStall);
         if (busRequest) begin
            accesses++;
            if (busAddress !== (v.addr & ~32'h3) || busWrite !== v.mw ||
                busByteEnable !== v.be || busWriteData !== v.bwd) stable = 0;
            if (accesses == v.waitc + 1) busReady = 1;
         end else begin
            done = 1;
            check({name, "_fault"}, 32'(misalignedFault), 32'(v.mis));
            check({name, "_buserr"}, 32'(busError), 32'(v.err));
            check({name, "_rdata"}, memoryReadData, v.rd);
         end
      end
      check({name, "_done_reached"}, 32'(done), 32'h1);
      if (accesses > 0) check({name, "_bus_fields"}, 32'(stable), 32'h1);
      check({name, "_access_cycles"}, 32'(accesses), 32'(v.mis ? 0 : v.lat - 2));
      check({name, "_latency"}, 32'(cyc), 32'(v.lat));
      check({name, "_stall_cycles"}, 32'(stalls), 32'(v.lat - 1));
      @(negedge clock);
      memoryRead = 0; memoryWrite = 0;
      #1;
      check({name, "_after_clear"}, {busRequest, pipelineStall, misalignedFault, busError},
            32'h0);
      check({name, "_hold"}, memoryReadData, v.rd);
   endtask

   vec_t tbl[14];
   logic [2:0] f3s[7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};

   initial begin
      // mr mw f3 addr wd word waitc | be bwd rd lat mis err
      tbl[0]  = '{1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'hF, 32'h0, 32'hDEADBEEF, 3, 0, 0};
      tbl[1]  = '{1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 0, 4'h8, 32'h0, 32'hFFFFFF80, 3, 0, 0};
      tbl[2]  = '{1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 0, 4'h8, 32'h0, 32'h00000080, 3, 0, 0};
      tbl[3]  = '{0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 3, 4'hC, 32'hABCDABCD, 32'h80, 6, 0, 0};
      tbl[4]  = '{1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 4'hF, 32'h0, 32'h80, 2, 1, 0};
      tbl[5]  = '{1, 0, 3'b001, 32'h102, 32'h0, 32'h80010000, 1, 4'hC, 32'h0, 32'hFFFF8001, 4, 0, 0};
      tbl[6]  = '{1, 0, 3'b101, 32'h002, 32'h0, 32'h12348765, 0, 4'hC, 32'h0, 32'h00001234, 3, 0, 0};
      tbl[7]  = '{0, 1, 3'b000, 32'h005, 32'h123456A5, 32'h0, 2, 4'h2, 32'hA5A5A5A5, 32'h1234, 5, 0, 0};
      tbl[8]  = '{0, 1, 3'b010, 32'h008, 32'hCAFEF00D, 32'h0, 1, 4'hF, 32'hCAFEF00D, 32'h1234, 4, 0, 0};
      tbl[9]  = '{0, 1, 3'b001, 32'h003, 32'h5555, 32'h0, 0, 4'h8, 32'h55555555, 32'h1234, 2, 1, 0};
      tbl[10] = '{1, 1, 3'b010, 32'h00C, 32'h11223344, 32'h0, 0, 4'hF, 32'h11223344, 32'h1234, 3, 0, 0};
      tbl[11] = '{1, 0, 3'b010, 32'h010, 32'h0, 32'h0, 99, 4'hF, 32'h0, 32'h0, 18, 0, 1};
      tbl[12] = '{1, 0, 3'b010, 32'h014, 32'h0, 32'h13579BDF, 15, 4'hF, 32'h0, 32'h13579BDF, 18, 0, 0};
      tbl[13] = '{1, 0, 3'b011, 32'h018, 32'h0, 32'h89ABCDEF, 0, 4'hF, 32'h0, 32'h89ABCDEF, 3, 0, 0};

      @(negedge clock); @(negedge clock);
      #1;
      check("reset_outputs", {busRequest, pipelineStall, misalignedFault, busError}, 32'h0);
      check("reset_rdata", memoryReadData, 32'h0);
      @(negedge clock);
      reset = 0;
      #1;
      check("idle_no_stall", {busRequest, pipelineStall}, 32'h0);

      busReady = 1; busReadData = 32'hFFFFFFFF;
      @(negedge clock);
      busReady = 0;
      #1;
      check("idle_ready_ignored", {busRequest, pipelineStall, busError}, 32'h0);
      check("idle_ready_rdata", memoryReadData, 32'h0);

      for (int i = 0; i < 14; i++) run_op($sformatf("vec%0d", i), tbl[i]);

      // Reset during the second ACCESS cycle abandons the transfer
      memoryRead = 1; funct3 = 3'b010; address = 32'h100; busReadData = 32'h5555AAAA;
      @(negedge clock);
      #1;
      check("rst_first_access", 32'(busRequest), 32'h1);
      @(negedge clock);
      #1;
      reset = 1; memoryRead = 0;
      #1;
      check("rst_async_req", {busRequest, pipelineStall}, 32'h0);
      check("rst_async_rdata", memoryReadData, 32'h0);
      @(negedge clock);
      reset = 0;
      #1;
      check("rst_idle", {busRequest, pipelineStall}, 32'h0);
      model_rd = 0;
      begin
         vec_t v = '{1, 0, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0};
         v = model(v, model_rd);
         run_op("rst_recover", v);
         model_rd = v.rd;
      end

      for (int i = 0; i < 40; i++) begin
         vec_t v;
         int kind = int'($urandom_range(0, 2));
         v.mr = kind != 1; v.mw = kind != 0;
         v.f3 = f3s[$urandom_range(0, 6)];
         v.addr = $urandom; v.wd = $urandom; v.word = $urandom;
         v.waitc = $urandom_range(0, 9) == 0 ? int'($urandom_range(16, 19)) : int'($urandom_range(0, 4));
         v = model(v, model_rd);
         run_op($sformatf("rnd%0d", i), v);
         model_rd = v.rd;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
